// File: rtl/modulo_tabuleiro_scan_pkg.sv
// Shared types and defaults for the battleship board: FSM states, display modes, board defaults.
package pkg_tabuleiro;

    localparam int DEF_ROWS  = 7;
    localparam int DEF_COLS  = 5;
    localparam int DEF_DWELL = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [1:0] MODE_BLANK = 2'b00;
    localparam logic [1:0] MODE_POS   = 2'b01;
    localparam logic [1:0] MODE_ATK   = 2'b10;

    // 7-bit result so a full 8x8 board (64 ships) is representable.
    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/modulo_tabuleiro_scan_coluna.sv
// Column scanner: prescaler holds each column DWELL cycles, then steps a one-hot column drive.
module modulo_scan_coluna
    import pkg_tabuleiro::*;
#(
    parameter int COLS  = DEF_COLS,
    parameter int DWELL = DEF_DWELL
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     run,
    output logic [$clog2(COLS)-1:0]  col_nxt,
    output logic [COLS-1:0]          m_col
);

    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(DWELL);

    logic [PW-1:0] pre;
    logic [CW-1:0] col_q;
    logic          pre_last;

    assign pre_last = (pre == PW'(DWELL - 1));

    // col_nxt is exported so the row drive can be registered in step with m_col.
    always_comb begin
        col_nxt = col_q;
        if (run && pre_last) begin
            col_nxt = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pre   <= '0;
            col_q <= '0;
            m_col <= COLS'(1);
        end else if (run) begin
            pre   <= pre_last ? '0 : pre + PW'(1);
            col_q <= col_nxt;
            m_col <= COLS'(1) << col_nxt;
        end
    end

endmodule

// File: rtl/modulo_tabuleiro_scan.sv
// Battleship board: ship-map load, attack resolution and multiplexed LED scan.
// Optional macro TABULEIRO_BLINK_EN makes hit cells blink in attack mode.
module modulo_tabuleiro_scan
    import pkg_tabuleiro::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int DWELL = DEF_DWELL
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [1:0]           mode,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [ROWS*COLS-1:0] load_map,
    input  logic                 atk_valid,
    output logic                 atk_ready,
    input  logic [2:0]           atk_row,
    input  logic [2:0]           atk_col,
    output logic                 atk_res_valid,
    output logic                 atk_hit,
    output logic                 atk_repeat,
    output logic                 atk_err,
    output logic [5:0]           hits_left,
    output logic                 game_over,
    output logic [COLS-1:0]      m_col,
    output logic [ROWS-1:0]      m_line,
    output state_t               state_dbg
);

    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(COLS);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both 1; ready never depends on valid, and the two readies are exclusive.

    state_t         state;
    logic [N-1:0]   ship_map;
    logic [N-1:0]   atk_map;
    logic [6:0]     hits_cnt;
    logic           run_q;
    logic [CW-1:0]  col_nxt;

    // Reset is released one edge late so the first state change lands on the second edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    modulo_scan_coluna #(
        .COLS  (COLS),
        .DWELL (DWELL)
    ) u_scan (
        .clk     (clk),
        .clr_n   (clr_n),
        .run     (run_q),
        .col_nxt (col_nxt),
        .m_col   (m_col)
    );

    assign load_ready = run_q && ((state == IDLE) || (state == OVER));
    assign atk_ready  = run_q && (state == PLAY);
    assign game_over  = (state == OVER);
    assign hits_left  = hits_cnt[6] ? 6'h3F : hits_cnt[5:0];
    assign state_dbg  = state;

    logic         row_ok, col_ok, in_range;
    logic [5:0]   cell_idx;
    logic [N-1:0] cell_mask;
    logic         cell_ship, cell_seen;
    logic [6:0]   load_pop;

    assign row_ok    = ({1'b0, atk_row} < 4'(ROWS));
    assign col_ok    = ({1'b0, atk_col} < 4'(COLS));
    assign in_range  = row_ok && col_ok;
    assign cell_idx  = 6'(atk_row) * 6'(COLS) + 6'(atk_col);
    assign cell_mask = N'(1) << cell_idx;
    assign cell_ship = |(ship_map & cell_mask);
    assign cell_seen = |(atk_map & cell_mask);
    assign load_pop  = popcount64(64'(load_map));

    logic [N-1:0] atk_lit;

`ifdef TABULEIRO_BLINK_EN
    logic [4:0] blink_cnt;
    logic       frame_wrap;

    // One frame is a full column sweep; bit 4 toggles every 16 frames.
    assign frame_wrap = run_q && m_col[COLS-1] && (col_nxt == '0);
    assign atk_lit    = atk_map & (~ship_map | {N{~blink_cnt[4]}});

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)          blink_cnt <= '0;
        else if (frame_wrap) blink_cnt <= blink_cnt + 5'd1;
    end
`else
    assign atk_lit = atk_map;
`endif

    logic [ROWS-1:0] pos_line, atk_line, line_nxt;

    always_comb begin
        pos_line = '0;
        atk_line = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (CW'(c) == col_nxt) begin
                    pos_line[r] = ship_map[r*COLS + c];
                    atk_line[r] = atk_lit[r*COLS + c];
                end
            end
        end
        if (mode == MODE_BLANK)    line_nxt = '1;
        else if (mode == MODE_ATK) line_nxt = ~atk_line;
        else                       line_nxt = ~pos_line;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state         <= IDLE;
            ship_map      <= '0;
            atk_map       <= '0;
            hits_cnt      <= '0;
            atk_res_valid <= 1'b0;
            atk_hit       <= 1'b0;
            atk_repeat    <= 1'b0;
            atk_err       <= 1'b0;
            m_line        <= '1;
        end else if (run_q) begin
            atk_res_valid <= 1'b0;
            atk_hit       <= 1'b0;
            atk_repeat    <= 1'b0;
            atk_err       <= 1'b0;
            m_line        <= line_nxt;
            case (state)
                IDLE, OVER: begin
                    if (load_valid) begin
                        ship_map <= load_map;
                        atk_map  <= '0;
                        hits_cnt <= load_pop;
                        state    <= (load_pop == 7'd0) ? OVER : PLAY;
                    end
                end
                PLAY: begin
                    if (atk_valid) begin
                        atk_res_valid <= 1'b1;
                        if (!in_range) begin
                            atk_err <= 1'b1;
                        end else if (cell_seen) begin
                            atk_repeat <= 1'b1;
                            atk_hit    <= cell_ship;
                        end else begin
                            atk_map <= atk_map | cell_mask;
                            atk_hit <= cell_ship;
                            if (cell_ship) begin
                                hits_cnt <= hits_cnt - 7'd1;
                                if (hits_cnt == 7'd1) state <= OVER;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modulo_tabuleiro_scan.sv
// Directed bench for modulo_tabuleiro_scan on a 7x5 board with a 4-cycle column dwell.
module tb_modulo_tabuleiro_scan;
    import pkg_tabuleiro::*;

    localparam int ROWS  = 7;
    localparam int COLS  = 5;
    localparam int DWELL = 4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic clr_n;

    logic [1:0]           mode;
    logic                 load_valid, load_ready;
    logic [ROWS*COLS-1:0] load_map;
    logic                 atk_valid, atk_ready;
    logic [2:0]           atk_row, atk_col;
    logic                 atk_res_valid, atk_hit, atk_repeat, atk_err;
    logic [5:0]           hits_left;
    logic                 game_over;
    logic [COLS-1:0]      m_col;
    logic [ROWS-1:0]      m_line;
    state_t               state_dbg;

    modulo_tabuleiro_scan #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL)) dut (
        .clk           (clk),
        .clr_n         (clr_n),
        .mode          (mode),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_map      (load_map),
        .atk_valid     (atk_valid),
        .atk_ready     (atk_ready),
        .atk_row       (atk_row),
        .atk_col       (atk_col),
        .atk_res_valid (atk_res_valid),
        .atk_hit       (atk_hit),
        .atk_repeat    (atk_repeat),
        .atk_err       (atk_err),
        .hits_left     (hits_left),
        .game_over     (game_over),
        .m_col         (m_col),
        .m_line        (m_line),
        .state_dbg     (state_dbg)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Edges seen since reset release; the expected scan column follows from it.
    int edges;
    always @(posedge clk) begin
        if (!clr_n) edges <= 0;
        else        edges <= edges + 1;
    end

    function automatic int exp_col();
        return ((edges - 1) / DWELL) % COLS;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic do_load(input logic [ROWS*COLS-1:0] map);
        load_map   = map;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_attack(input int r, input int c);
        atk_row   = 3'(r);
        atk_col   = 3'(c);
        atk_valid = 1'b1;
        tick();
        atk_valid = 1'b0;
    endtask

    task automatic wait_col(input int c);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (exp_col() == c) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_col", 64'(found), 64'd1);
    endtask

    initial begin
        logic [COLS-1:0] exp_mc;

        clr_n      = 1'b0;
        mode       = 2'b01;
        load_valid = 1'b0;
        load_map   = '0;
        atk_valid  = 1'b0;
        atk_row    = '0;
        atk_col    = '0;
        repeat (3) tick();

        check("rst_state",  64'(state_dbg), 64'(IDLE));
        check("rst_hits",   64'(hits_left), 64'd0);
        check("rst_over",   64'(game_over), 64'd0);
        check("rst_resv",   64'(atk_res_valid), 64'd0);
        check("rst_mcol",   64'(m_col), 64'b00001);
        check("rst_mline",  64'(m_line), 64'h7F);
        check("rst_atkrdy", 64'(atk_ready), 64'd0);

        // Scan: each column held DWELL cycles from the first edge after release.
        clr_n = 1'b1;
        for (int k = 0; k < 22; k++) begin
            tick();
            exp_mc = COLS'(1) << ((k / DWELL) % COLS);
            check("scan_mcol", 64'(m_col), 64'(exp_mc));
            if (k == 0) check("rel_state", 64'(state_dbg), 64'(IDLE));
        end
        check("idle_ldrdy", 64'(load_ready), 64'd1);

        // Empty map goes straight to OVER.
        do_load('0);
        check("empty_state", 64'(state_dbg), 64'(OVER));
        check("empty_over",  64'(game_over), 64'd1);
        check("empty_hits",  64'(hits_left), 64'd0);
        check("empty_ldrdy", 64'(load_ready), 64'd1);

        // Ships at (0,0), (1,2), (3,4).
        do_load(35'h0_0008_0081);
        check("load_hits",   64'(hits_left), 64'd3);
        check("load_state",  64'(state_dbg), 64'(PLAY));
        check("load_ldrdy",  64'(load_ready), 64'd0);
        check("load_atkrdy", 64'(atk_ready), 64'd1);
        check("load_over",   64'(game_over), 64'd0);

        do_attack(0, 0);
        check("a00_resv", 64'(atk_res_valid), 64'd1);
        check("a00_hit",  64'(atk_hit), 64'd1);
        check("a00_rep",  64'(atk_repeat), 64'd0);
        check("a00_err",  64'(atk_err), 64'd0);
        check("a00_hits", 64'(hits_left), 64'd2);
        tick();
        check("a00_pulse", 64'(atk_res_valid), 64'd0);

        do_attack(0, 0);
        check("rep_resv", 64'(atk_res_valid), 64'd1);
        check("rep_rep",  64'(atk_repeat), 64'd1);
        check("rep_hit",  64'(atk_hit), 64'd1);
        check("rep_hits", 64'(hits_left), 64'd2);

        do_attack(7, 0);
        check("err_resv",  64'(atk_res_valid), 64'd1);
        check("err_err",   64'(atk_err), 64'd1);
        check("err_hit",   64'(atk_hit), 64'd0);
        check("err_rep",   64'(atk_repeat), 64'd0);
        check("err_hits",  64'(hits_left), 64'd2);
        check("err_state", 64'(state_dbg), 64'(PLAY));

        do_attack(2, 1);
        check("miss_resv", 64'(atk_res_valid), 64'd1);
        check("miss_hit",  64'(atk_hit), 64'd0);
        check("miss_rep",  64'(atk_repeat), 64'd0);
        check("miss_err",  64'(atk_err), 64'd0);
        check("miss_hits", 64'(hits_left), 64'd2);

        // Display modes.
        mode = 2'b10;
        wait_col(1);
        check("atk_c1_line", 64'(m_line), 64'b1111011);
        check("atk_c1_mcol", 64'(m_col), 64'b00010);
        mode = 2'b00;
        tick();
        check("blank_line", 64'(m_line), 64'h7F);
        exp_mc = COLS'(1) << exp_col();
        check("blank_mcol", 64'(m_col), 64'(exp_mc));
        mode = 2'b11;
        wait_col(2);
        check("pos11_c2_line", 64'(m_line), 64'b1111101);
        mode = 2'b01;
        wait_col(0);
        check("pos01_c0_line", 64'(m_line), 64'b1111110);
        mode = 2'b10;
        wait_col(0);
        check("atk_c0_line", 64'(m_line), 64'b1111110);

        do_attack(1, 2);
        check("a12_hit",  64'(atk_hit), 64'd1);
        check("a12_hits", 64'(hits_left), 64'd1);
        check("a12_over", 64'(game_over), 64'd0);

        do_attack(3, 4);
        check("last_resv",  64'(atk_res_valid), 64'd1);
        check("last_hit",   64'(atk_hit), 64'd1);
        check("last_over",  64'(game_over), 64'd1);
        check("last_hits",  64'(hits_left), 64'd0);
        check("last_state", 64'(state_dbg), 64'(OVER));
        check("last_atkrdy", 64'(atk_ready), 64'd0);
        check("last_ldrdy", 64'(load_ready), 64'd1);

        do_attack(3, 4);
        check("over_noacc", 64'(atk_res_valid), 64'd0);

        // New game: single ship at (6,4).
        do_load(35'h4_0000_0000);
        check("reload_hits",  64'(hits_left), 64'd1);
        check("reload_state", 64'(state_dbg), 64'(PLAY));
        check("reload_over",  64'(game_over), 64'd0);

        do_attack(6, 4);
        check("inflight_resv", 64'(atk_res_valid), 64'd1);
        clr_n = 1'b0;
        #1;
        check("midrst_resv",  64'(atk_res_valid), 64'd0);
        check("midrst_hit",   64'(atk_hit), 64'd0);
        check("midrst_over",  64'(game_over), 64'd0);
        check("midrst_hits",  64'(hits_left), 64'd0);
        check("midrst_state", 64'(state_dbg), 64'(IDLE));
        check("midrst_mcol",  64'(m_col), 64'b00001);
        check("midrst_mline", 64'(m_line), 64'h7F);
        check("midrst_atkrdy", 64'(atk_ready), 64'd0);

        repeat (2) tick();
        clr_n = 1'b1;
        tick();
        check("rel2_state", 64'(state_dbg), 64'(IDLE));
        tick();
        check("rel2_ldrdy", 64'(load_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/modulo_tabuleiro_scan.md
MODULO_TABULEIRO_SCAN -- requirements
Module: modulo_tabuleiro_scan

Interface
REQ-001 SHALL have parameter ROWS, default 7: board rows, range 2..8.
REQ-002 SHALL have parameter COLS, default 5: board columns, range 2..8.
REQ-003 SHALL have parameter DWELL, default 1024: clk cycles each scan column is held, at least 2.
REQ-004 SHALL have port clk, input, width 1: single clock; all state on its rising edge.
REQ-005 SHALL have port clr_n, input, width 1: reset, asynchronous assertion, active-low.
REQ-006 SHALL have port mode, input, width 2: display mode; 00 = blank, 01 = position, 10 = attack, 11 = position.
REQ-007 SHALL have ports load_valid (input, 1), load_ready (output, 1) and load_map (input, ROWS*COLS): ship-map load handshake; bit r*COLS+c is cell (r,c).
REQ-008 SHALL have ports atk_valid (input, 1), atk_ready (output, 1), atk_row (input, 3) and atk_col (input, 3): attack command handshake.
REQ-009 SHALL have ports atk_res_valid, atk_hit, atk_repeat and atk_err (all output, 1): attack result, one-cycle pulse with flags.
REQ-010 SHALL have port hits_left, output, width 6: count of unhit ship cells.
REQ-011 SHALL have port game_over, output, width 1: all ships sunk.
REQ-012 SHALL have port m_col, output, width COLS: one-hot scan column, active-high.
REQ-013 SHALL have port m_line, output, width ROWS: row drive, active-low (1 = LED off).

Function
REQ-014 SHALL implement FSM states IDLE, PLAY and OVER; reset state is IDLE.
REQ-015 SHALL drive load_ready=1 only in IDLE or OVER.
REQ-016 On a load handshake, SHALL register load_map, clear the attack map and set hits_left=popcount(load_map); next state is PLAY, or OVER if popcount=0.
REQ-017 SHALL drive atk_ready=1 only in PLAY; attacks presented in other states are not accepted.
REQ-018 For each accepted attack, SHALL pulse atk_res_valid exactly one cycle after the handshake, with flags valid in that same cycle.
REQ-019 For an out-of-range attack (row>=ROWS or col>=COLS), SHALL report atk_err=1, atk_hit=0, atk_repeat=0 and change no state.
REQ-020 For a repeat attack (cell already attacked), SHALL report atk_repeat=1 and atk_hit=stored ship bit, leave hits_left unchanged, and change no map bit.
REQ-021 For a new attack, SHALL set the attack-map bit and report atk_hit=ship bit; on a hit, SHALL decrement hits_left.
REQ-022 When a decrement reaches 0, SHALL enter OVER and assert game_over in the same cycle as atk_res_valid.
REQ-023 SHALL hold game_over=1 throughout OVER and 0 in all other states.
REQ-024 SHALL advance the scan column index every DWELL cycles, counting 0..COLS-1 and wrapping to 0.
REQ-025 SHALL keep m_col exactly one-hot at all times, including in mode 00.
REQ-026 In modes 01 and 11, SHALL drive m_line[r] = ~ship(r,col).
REQ-027 In mode 10, SHALL drive m_line[r] = ~attacked(r,col).
REQ-028 In mode 00, SHALL drive all m_line bits to 1.
REQ-029 SHALL register m_col and m_line; a mode change is visible on the next clk edge.
REQ-030 SHALL never assert load_ready and atk_ready in the same cycle.

Reset
REQ-031 While clr_n=0, SHALL hold: state IDLE; ship map, attack map and hits_left = 0; game_over, atk_res_valid and all flags = 0; column index 0 (m_col = 1); m_line = all 1s; prescaler 0.
REQ-032 Reset asserted mid-game SHALL discard any in-flight result pulse.
REQ-033 SHALL release reset so that the first state change occurs on the second clk edge after clr_n rises.

Configuration
REQ-034 Macro TABULEIRO_BLINK_EN, when defined, SHALL make hit cells in mode 10 blink at a period of 2*COLS*DWELL*16 cycles (lit half the period); missed cells remain steady lit.
REQ-035 Without TABULEIRO_BLINK_EN, SHALL light all attacked cells steadily and compile in no blink counter.

Structure
REQ-036 SHALL take the state enum, the mode encodings (MODE_BLANK, MODE_POS, MODE_ATK) and the default ROWS/COLS/DWELL from a shared package, pkg_tabuleiro.
REQ-037 SHALL instantiate a sub-module modulo_scan_coluna containing the prescaler, column counter and one-hot m_col generation, parametrised by COLS and DWELL.

Verification
REQ-038 SHALL cover: reset, then DWELL=4, COLS=5 -> m_col sequence 00001, 00010, ..., 10000, 00001, each held 4 cycles.
REQ-039 SHALL cover: load_map with 3 bits set -> hits_left=3, state PLAY, load_ready=0, atk_ready=1.
REQ-040 SHALL cover: attack (0,0) on a ship -> atk_hit=1 one cycle later, hits_left=2; repeating (0,0) -> atk_repeat=1, hits_left still 2.
REQ-041 SHALL cover: attack (7,0) with ROWS=7 -> atk_err=1, no state change.
REQ-042 SHALL cover: hitting the last ship cell -> atk_res_valid, atk_hit and game_over all 1 in the same cycle; atk_ready=0 afterwards; a new load is accepted.
REQ-043 SHALL cover: mode 10 after a miss at (2,1) while column 1 is scanned -> m_line = 1111011; clr_n pulsed low mid-game -> all outputs at reset values.
